// File: rtl/param_sync_fifo.sv
// Parametrised single-clock FIFO with selectable registered or first-word-fall-through read,
// threshold flags, occupancy count, synchronous flush and sticky overflow/underflow flags.
module param_sync_fifo #(
   parameter int DATA_W    = 32,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 2,
   parameter int AE_THRESH = 2,
   parameter int FWFT      = 0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         write,
   input  logic [DATA_W-1:0]            wData,
   input  logic                         read,
   output logic [DATA_W-1:0]            rdData,
   output logic                         rdValid,
   output logic                         empty,
   output logic                         full,
   output logic                         almost_full,
   output logic                         almost_empty,
   output logic [$clog2(DEPTH+1)-1:0]   count,
   output logic                         overflow,
   output logic                         underflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   logic [DATA_W-1:0] mem_q [DEPTH];

   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              ovf_q, ovf_d;
   logic              udf_q, udf_d;

   logic              empty_w, full_w;
   logic              rd_acc, wr_acc;

   assign empty_w = (count_q == '0);
   assign full_w  = (count_q == CW'(DEPTH));

   // Flush suppresses both accepts so nothing moves and no error flag is raised that cycle.
   assign rd_acc = read & ~empty_w & ~flush;
   assign wr_acc = write & (~full_w | rd_acc) & ~flush;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;
      rd_data_d  = rd_data_q;
      rd_valid_d = 1'b0;
      ovf_d      = ovf_q;
      udf_d      = udf_q;

      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         udf_d    = 1'b0;
      end else begin
         if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
         if (rd_acc) rd_ptr_d = rd_ptr_q + AW'(1);

         if (wr_acc && !rd_acc)      count_d = count_q + CW'(1);
         else if (rd_acc && !wr_acc) count_d = count_q - CW'(1);

         if (rd_acc && (FWFT == 0)) begin
            rd_data_d  = mem_q[rd_ptr_q];
            rd_valid_d = 1'b1;
         end

         if (write && !wr_acc) ovf_d = 1'b1;
         if (read && empty_w)  udf_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         ovf_q      <= 1'b0;
         udf_q      <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         ovf_q      <= ovf_d;
         udf_q      <= udf_d;
      end
   end

   // Storage is intentionally not reset.
   always_ff @(posedge clk) begin
      if (wr_acc) mem_q[wr_ptr_q] <= wData;
   end

   assign rdData       = (FWFT != 0) ? mem_q[rd_ptr_q] : rd_data_q;
   assign rdValid      = (FWFT != 0) ? ~empty_w : rd_valid_q;
   assign empty        = empty_w;
   assign full         = full_w;
   assign almost_full  = (count_q >= CW'(AF_THRESH));
   assign almost_empty = (count_q <= CW'(AE_THRESH));
   assign count        = count_q;
   assign overflow     = ovf_q;
   assign underflow    = udf_q;

endmodule

// File: tb/tb_param_sync_fifo.sv
// Directed bench for param_sync_fifo: one registered-read instance and one FWFT instance
// share stimulus; each scenario task checks its own expected values inline.
module tb_param_sync_fifo;

   localparam int DW = 16;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          flush = 1'b0;
   logic          write = 1'b0;
   logic          read = 1'b0;
   logic [DW-1:0] wData = '0;

   logic [DW-1:0] rd0, rd1;
   logic          rv0, rv1, em0, em1, fu0, fu1, af0, af1, ae0, ae1, ov0, ov1, un0, un1;
   logic [3:0]    cnt0, cnt1;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   param_sync_fifo #(.DATA_W(DW), .DEPTH(8), .FWFT(0)) dut0 (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .wData(wData), .read(read),
      .rdData(rd0), .rdValid(rv0), .empty(em0), .full(fu0), .almost_full(af0),
      .almost_empty(ae0), .count(cnt0), .overflow(ov0), .underflow(un0));

   param_sync_fifo #(.DATA_W(DW), .DEPTH(8), .FWFT(1)) dut1 (
      .clk(clk), .rst(rst), .flush(flush), .write(write), .wData(wData), .read(read),
      .rdData(rd1), .rdValid(rv1), .empty(em1), .full(fu1), .almost_full(af1),
      .almost_empty(ae1), .count(cnt1), .overflow(ov1), .underflow(un1));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      #2;
      checks++; if (cnt0 !== 4'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", cnt0); end
      checks++; if ({em0, fu0, ae0, af0} !== 4'b1010) begin failures++; $display("FAIL reset_flags got=%b exp=1010", {em0, fu0, ae0, af0}); end
      checks++; if ({rv0, ov0, un0} !== 3'b000) begin failures++; $display("FAIL reset_valid_err got=%b exp=000", {rv0, ov0, un0}); end
      checks++; if (rd0 !== 16'h0000) begin failures++; $display("FAIL reset_rddata got=%h exp=0000", rd0); end
      checks++; if (rv1 !== 1'b0) begin failures++; $display("FAIL reset_fwft_valid got=%b exp=0", rv1); end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_fill_drain;
      for (int i = 0; i < 8; i++) begin
         write = 1'b1; wData = DW'(16'h10 + i);
         tick();
         checks++; if (cnt0 !== 4'(i + 1)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, cnt0, i + 1); end
         checks++; if (af0 !== ((i + 1) >= 6)) begin failures++; $display("FAIL fill_af[%0d] got=%b exp=%b", i, af0, (i + 1) >= 6); end
      end
      write = 1'b0;
      checks++; if ({fu0, em0} !== 2'b10) begin failures++; $display("FAIL fill_full got=%b exp=10", {fu0, em0}); end
      for (int i = 0; i < 8; i++) begin
         read = 1'b1;
         tick();
         checks++; if ({rv0, rd0} !== {1'b1, DW'(16'h10 + i)}) begin failures++; $display("FAIL drain_data[%0d] got=%b/%h exp=1/%h", i, rv0, rd0, 16'h10 + i); end
      end
      read = 1'b0;
      tick();
      checks++; if ({rv0, em0, cnt0} !== {2'b01, 4'd0}) begin failures++; $display("FAIL drain_end got=%b/%b/%0d exp=0/1/0", rv0, em0, cnt0); end
   endtask

   task automatic test_wrap;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 6; i++) begin
            write = 1'b1; wData = DW'(16'hA0 + pass * 6 + i);
            tick();
         end
         write = 1'b0;
         for (int i = 0; i < 6; i++) begin
            read = 1'b1;
            tick();
            checks++; if (rd0 !== DW'(16'hA0 + pass * 6 + i)) begin failures++; $display("FAIL wrap_data[%0d] got=%h exp=%h", pass * 6 + i, rd0, 16'hA0 + pass * 6 + i); end
         end
         read = 1'b0;
      end
      checks++; if ({cnt0, ov0, un0} !== {4'd0, 2'b00}) begin failures++; $display("FAIL wrap_end got=%0d/%b/%b exp=0/0/0", cnt0, ov0, un0); end
   endtask

   task automatic test_full_boundary;
      logic [DW-1:0] exp_q [8];
      for (int i = 0; i < 8; i++) begin
         write = 1'b1; wData = DW'(16'hC0 + i);
         tick();
      end
      read = 1'b1; wData = 16'hBEEF;
      tick();
      checks++; if ({cnt0, ov0} !== {4'd8, 1'b0}) begin failures++; $display("FAIL full_rw got=%0d/%b exp=8/0", cnt0, ov0); end
      checks++; if (rd0 !== 16'h00C0) begin failures++; $display("FAIL full_rw_pop got=%h exp=00c0", rd0); end
      read = 1'b0; wData = 16'h1234;
      tick();
      checks++; if ({cnt0, ov0} !== {4'd8, 1'b1}) begin failures++; $display("FAIL full_drop got=%0d/%b exp=8/1", cnt0, ov0); end
      write = 1'b0;
      for (int i = 0; i < 7; i++) exp_q[i] = DW'(16'hC1 + i);
      exp_q[7] = 16'hBEEF;
      for (int i = 0; i < 8; i++) begin
         read = 1'b1;
         tick();
         checks++; if (rd0 !== exp_q[i]) begin failures++; $display("FAIL full_drain[%0d] got=%h exp=%h", i, rd0, exp_q[i]); end
      end
      read = 1'b0;
      checks++; if (em0 !== 1'b1) begin failures++; $display("FAIL full_drain_empty got=%b exp=1", em0); end
   endtask

   task automatic test_empty_boundary;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if (ov0 !== 1'b0) begin failures++; $display("FAIL flush_clears_ovf got=%b exp=0", ov0); end
      read = 1'b1; write = 1'b1; wData = 16'h0055;
      tick();
      checks++; if ({cnt0, un0, rv0} !== {4'd1, 2'b10}) begin failures++; $display("FAIL empty_rw got=%0d/%b/%b exp=1/1/0", cnt0, un0, rv0); end
      write = 1'b0;
      tick();
      checks++; if ({rv0, rd0, cnt0} !== {1'b1, 16'h0055, 4'd0}) begin failures++; $display("FAIL empty_rw_pop got=%b/%h/%0d exp=1/0055/0", rv0, rd0, cnt0); end
      read = 1'b0;
   endtask

   task automatic test_fwft;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      checks++; if ({rv1, un1} !== 2'b00) begin failures++; $display("FAIL fwft_idle got=%b exp=00", {rv1, un1}); end
      write = 1'b1; wData = 16'h0001;
      tick();
      checks++; if ({rv1, rd1} !== {1'b1, 16'h0001}) begin failures++; $display("FAIL fwft_first got=%b/%h exp=1/0001", rv1, rd1); end
      wData = 16'h0002;
      tick();
      write = 1'b0;
      checks++; if ({rd1, cnt1} !== {16'h0001, 4'd2}) begin failures++; $display("FAIL fwft_hold got=%h/%0d exp=0001/2", rd1, cnt1); end
      read = 1'b1;
      tick();
      checks++; if ({rv1, rd1} !== {1'b1, 16'h0002}) begin failures++; $display("FAIL fwft_second got=%b/%h exp=1/0002", rv1, rd1); end
      tick();
      read = 1'b0;
      checks++; if ({rv1, em1, un1} !== 3'b010) begin failures++; $display("FAIL fwft_empty got=%b exp=010", {rv1, em1, un1}); end
   endtask

   task automatic test_flush;
      for (int i = 0; i < 9; i++) begin
         write = 1'b1; wData = DW'(16'h30 + i);
         tick();
      end
      write = 1'b0;
      for (int i = 0; i < 3; i++) begin
         read = 1'b1;
         tick();
      end
      read = 1'b0;
      checks++; if ({cnt0, ov0, rd0} !== {4'd5, 1'b1, 16'h0032}) begin failures++; $display("FAIL flush_pre got=%0d/%b/%h exp=5/1/0032", cnt0, ov0, rd0); end
      flush = 1'b1; write = 1'b1; wData = 16'h0099;
      tick();
      flush = 1'b0; write = 1'b0;
      checks++; if ({cnt0, ov0, rv0, em0} !== {4'd0, 3'b001}) begin failures++; $display("FAIL flush_state got=%0d/%b/%b/%b exp=0/0/0/1", cnt0, ov0, rv0, em0); end
      checks++; if (rd0 !== 16'h0032) begin failures++; $display("FAIL flush_rddata_hold got=%h exp=0032", rd0); end
      tick();
      checks++; if (cnt0 !== 4'd0) begin failures++; $display("FAIL flush_write_ignored got=%0d exp=0", cnt0); end
   endtask

   task automatic test_async_reset;
      for (int i = 0; i < 3; i++) begin
         write = 1'b1; wData = DW'(16'h40 + i);
         tick();
      end
      #2;
      rst = 1'b0;
      #1;
      checks++; if ({cnt0, em0, ae0, rv0, ov0, un0} !== {4'd0, 5'b11000}) begin failures++; $display("FAIL async_rst got=%0d/%b%b%b%b%b exp=0/11000", cnt0, em0, ae0, rv0, ov0, un0); end
      checks++; if ({rd0, rv1} !== {16'h0000, 1'b0}) begin failures++; $display("FAIL async_rst_data got=%h/%b exp=0000/0", rd0, rv1); end
      tick();
      checks++; if (cnt0 !== 4'd0) begin failures++; $display("FAIL rst_held got=%0d exp=0", cnt0); end
      @(negedge clk);
      rst = 1'b1; wData = 16'h0077;
      tick();
      write = 1'b0;
      checks++; if ({cnt0, rd1} !== {4'd1, 16'h0077}) begin failures++; $display("FAIL rst_resume got=%0d/%h exp=1/0077", cnt0, rd1); end
   endtask

   initial begin
      test_reset();
      test_fill_drain();
      test_wrap();
      test_full_boundary();
      test_empty_boundary();
      test_fwft();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/param_sync_fifo.md
Name: param_sync_fifo

Overview:
Parametrised single-clock FIFO. It is the next generation of the baseline 8x32 FIFO and is used by the scheduling queue and ROB. It adds configurable width and depth, a selectable first-word-fall-through (FWFT) read mode, almost-full and almost-empty thresholds, an occupancy count output, a synchronous flush, and sticky overflow/underflow error flags. Its key rule: a write and a read in the same cycle at the full boundary are both accepted.

Parameters:
DATA_W, 32, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of contents and error flags
write  in  1  push request
wData  in  DATA_W  push data
read  in  1  pop request
rdData  out  DATA_W  read data
rdValid  out  1  rdData holds a valid popped word (FWFT=0) or a valid head word (FWFT=1)
empty  out  1  count == 0
full  out  1  count == DEPTH
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  $clog2(DEPTH+1)  current occupancy
overflow  out  1  sticky: a write was dropped
underflow  out  1  sticky: a read was issued while empty

Behaviour:
- Reset (rst=0, async): pointers=0, count=0, rdData=0, rdValid=0, overflow=0, underflow=0. Resulting outputs: empty=1, full=0, almost_empty=1, almost_full=0. Memory contents are not reset.
- Acceptance, evaluated from the registered count at the clock edge:
  - rd_acc = read & ~empty.
  - wr_acc = write & (~full | rd_acc). When full, a simultaneous read+write is accepted; count stays at DEPTH.
  - When empty, read+write: the write is accepted, the read is rejected, and underflow is set.
- Count: +1 on wr_acc&~rd_acc; -1 on rd_acc&~wr_acc; unchanged otherwise. It never exceeds DEPTH and never goes below 0.
- Pointers: log2(DEPTH) bits each; they wrap naturally from DEPTH-1 to 0. The write pointer advances on wr_acc, the read pointer on rd_acc.
- FWFT=0:
  - On rd_acc, rdData <= mem[r_ptr] at the edge, and rdValid=1 for the next cycle only.
  - Otherwise rdValid=0 and rdData holds its last value.
  - Read latency is 1 cycle.
- FWFT=1:
  - rdData = mem[r_ptr] combinationally and rdValid = ~empty. rdData is don't-care when empty.
  - read acts as an acknowledge: the next word appears in the cycle after the pop.
  - A word written into an empty FIFO appears on rdData the cycle after the write.
- Error flags:
  - overflow is set when write & ~wr_acc.
  - underflow is set when read & empty.
  - Both are sticky until reset or flush. The dropped write does not modify memory or pointers.
- Flush:
  - Takes priority over read and write in the same cycle; both requests are ignored and no flags are set.
  - Next cycle: pointers=0, count=0, overflow=0, underflow=0, rdValid=0.
  - rdData keeps its value in FWFT=0.
- Reset asserted mid-operation clears state immediately. Operation resumes on the first rising edge after rst deasserts.
- Threshold outputs and empty/full are combinational decodes of the registered count, so they are glitch-free relative to clk.

Test Plan:
- Fill/drain, FWFT=0, DEPTH=8: write 0x10..0x17 over 8 cycles -> full=1, count=8, almost_full asserted from count=6. Then read 8 times -> rdData=0x10..0x17, each one cycle after its read, with rdValid pulsing; empty=1 at the end.
- Wrap-around: write 6, read 6, write 6, read 6 with values 0xA0.. -> data emerges in order; count returns to 0; no flags set.
- Full boundary: with count=8, assert read+write(0xBEEF) -> count stays 8 and overflow=0; the popped word is the oldest. Then write alone -> overflow=1, count=8, and 0xBEEF is the last word out.
- Empty boundary: with count=0, assert read+write(0x55) -> count=1, underflow=1. The next read returns 0x55.
- FWFT=1: write 0x1 then 0x2 -> rdValid=1 and rdData=0x1 the cycle after the first write. After a read pulse, rdData=0x2. After a second read, rdValid=0.
- Flush and reset: with count=5, overflow=1, assert flush with write=1 -> next cycle count=0, overflow=0, write ignored. Assert rst low mid-burst -> all outputs return to reset values asynchronously.
